ahb_sram_subordinate: RTL and testbench
=======================================

Name: ahb_sram_subordinate

Overview:
AHB responder (subordinate) that serves a single-port word-addressed SRAM array at the far end of the bus driven by the team's AHB manager. It decodes address/data phases, inserts programmable wait states, and returns OKAY, ERROR or injected RETRY with the two-cycle response protocol. It is the reference target for manager bring-up, burst, 1 KB-boundary and SPLIT/RETRY-rollback testing.

Parameters:
DATA_WDT, 32, data bus width in bits (32 or 64).
DEPTH_LOG2, 10, log2 of SRAM depth in DATA_WDT-bit words.
WAIT_STATES, 0, wait cycles (hready low, OKAY) inserted in every SEQ/NONSEQ data phase; range 0..15.

Ports:
i_hclk  in  1  clock.
i_hreset_n  in  1  reset, asynchronous, active-low.
i_hsel  in  1  subordinate select.
i_haddr  in  32  address.
i_htrans  in  t_htrans  transfer type.
i_hwrite  in  1  1 = write.
i_hsize  in  t_hsize  transfer size.
i_hburst  in  t_hburst  burst type; informational only.
i_hwdata  in  DATA_WDT  write data (data phase).
i_hready  in  1  bus-level HREADY (previous transfer complete).
o_hready  out  1  subordinate HREADYOUT.
o_hresp  out  t_hresp  response.
o_hrdata  out  DATA_WDT  read data.
i_retry_inj  in  1  single-cycle pulse: answer next accepted transfer with RETRY.

Behaviour:
- Reset: o_hready=1, o_hresp=OKAY, o_hrdata=0, FSM=S_IDLE, retry flag=0, wait counter=0. SRAM contents not reset. Reset mid-transfer aborts it; no write occurs.
- Accept: address phase sampled at posedge when i_hsel & i_hready. IDLE/BUSY, or i_hsel=0: zero-wait OKAY, no access.
- SEQ/NONSEQ accepted: latch addr, write, size; classify:
  - ERROR if i_haddr[31:DEPTH_LOG2+log2(DATA_WDT/8)] != 0, or (8<<hsize) > DATA_WDT, or address misaligned for hsize.
  - else RETRY if retry flag set; flag clears.
  - else OKAY access. ERROR has precedence; a pending retry flag stays set through an ERROR.
- Retry flag sets on i_retry_inj; set and consume in the same cycle leaves it set.
- FSM:
  - S_IDLE: o_hready=1, OKAY. OKAY access with WAIT_STATES>0 goes to S_WAIT (counter=WAIT_STATES). WAIT_STATES=0 stays in S_IDLE with data phase completing next cycle. ERROR/RETRY goes to S_RESP1.
  - S_WAIT: o_hready=0, OKAY, counter decrements; at 1 goes to S_IDLE (data phase completes on that next cycle).
  - S_RESP1: o_hready=0, o_hresp=ERROR/RETRY. Always goes to S_RESP2.
  - S_RESP2: o_hready=1, same resp. Next is S_IDLE, or a new classification if a transfer is accepted this cycle.
- ERROR/RETRY data phase never writes SRAM. o_hrdata is held at its previous value.
- Write: bytes committed at the posedge ending the data phase (o_hready=1). Byte lanes come from latched addr[log2(DATA_WDT/8)-1:0] and size, little-endian; other bytes are untouched.
- Read: o_hrdata valid in the cycle o_hready=1 ending the data phase. Full word is returned; the manager selects lanes.
- Read-after-write hazard: a read address phase accepted on the same edge a write to the same word commits returns merged data (new bytes from i_hwdata, rest from SRAM).
- Latency: WAIT_STATES+1 cycles address-to-data for OKAY; 2 data-phase cycles for ERROR/RETRY.
- Bursts: each beat is handled independently. No wrap/INCR computation is needed because the manager supplies every address. BUSY beats insert no access.

Test Plan:
- WAIT_STATES=0: INCR4 word write 0x100..0x10C with data 0xA0..0xA3, then INCR4 read -> 0xA0..0xA3, o_hready stays high, OKAY each beat.
- WAIT_STATES=2: single NONSEQ read 0x20 -> o_hready low for 2 cycles then high with data, OKAY throughout.
- Byte write 0xEE to 0x103 over word 0x11223344 at 0x100 -> read 0x100 returns 0xEE223344.
- Write 0x55 word to 0x40 immediately followed by NONSEQ read 0x40 -> read data 0x00000055 (forwarding).
- Access 0x0001_0000 (DEPTH_LOG2=10) and halfword at 0x101 -> ERROR (hready 0 then 1), SRAM unchanged.
- Pulse i_retry_inj then NONSEQ write 0x80=0x1234 -> RETRY two-cycle response, no write. Manager reissue -> OKAY, read back 0x1234.

Source files
------------

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate that fronts a single-port, word-addressed SRAM. It supports programmable
// wait states, two-cycle ERROR/RETRY responses and a one-shot RETRY injection.
// Ports: AHB address/control/data inputs (i_h*), bus-level i_hready, and the i_retry_inj pulse.
//        Responses are o_hready (HREADYOUT), o_hresp and o_hrdata, all registered.
module ahb_sram_subordinate #(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic                o_hready,
  output logic [1:0]          o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata,
  input  logic                i_retry_inj
);

  localparam int NB  = DATA_WDT / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = DEPTH_LOG2 + OFS;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP1, S_RESP2} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  retry_flag;
  logic                  dp_vld;
  logic                  dp_wr;
  logic [DEPTH_LOG2-1:0] dp_idx;
  logic [NB-1:0]         dp_be;
  logic [DATA_WDT-1:0]   mem [2**DEPTH_LOG2];

  logic                  acc;
  logic                  acc_xfer;
  logic                  bad;
  logic                  misalign;
  logic                  take_err;
  logic                  take_retry;
  logic                  take_ok;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic [OFS-1:0]        a_ofs;
  logic [NB-1:0]         a_be;
  logic [DATA_WDT-1:0]   rd_word;
  logic                  unused_hburst;

  // The burst type is informational only; each beat carries its own address.
  assign unused_hburst = ^i_hburst;

  // An address phase is accepted only when our own previous data phase is finishing.
  assign acc      = i_hsel & i_hready & o_hready;
  assign acc_xfer = acc & ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));

  always_comb begin
    a_idx    = i_haddr[AW-1:OFS];
    a_ofs    = i_haddr[OFS-1:0];
    misalign = 1'b0;
    for (int i = 0; i < OFS; i++)
      if (i < int'(i_hsize) && i_haddr[i]) misalign = 1'b1;
    a_be = '0;
    for (int b = 0; b < NB; b++)
      if (b >= int'(a_ofs) && b < int'(a_ofs) + (1 << int'(i_hsize))) a_be[b] = 1'b1;
  end

  assign bad        = ((i_haddr >> AW) != 32'd0) | (int'(i_hsize) > OFS) | misalign;
  assign take_err   = acc_xfer & bad;
  assign take_retry = acc_xfer & ~bad & retry_flag;
  assign take_ok    = acc_xfer & ~bad & ~retry_flag;
  assign commit     = dp_vld & dp_wr & o_hready;

  // A read accepted on the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    rd_word = mem[a_idx];
    if (commit && dp_idx == a_idx)
      for (int b = 0; b < NB; b++)
        if (dp_be[b]) rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
  end

  always_ff @(posedge i_hclk) begin
    if (commit)
      for (int b = 0; b < NB; b++)
        if (dp_be[b]) mem[dp_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state      <= S_IDLE;
      o_hready   <= 1'b1;
      o_hresp    <= HRESP_OKAY;
      o_hrdata   <= '0;
      retry_flag <= 1'b0;
      wait_cnt   <= 4'd0;
      dp_vld     <= 1'b0;
      dp_wr      <= 1'b0;
      dp_idx     <= '0;
      dp_be      <= '0;
    end else begin
      // A new injection wins over consumption in the same cycle.
      if (i_retry_inj)     retry_flag <= 1'b1;
      else if (take_retry) retry_flag <= 1'b0;

      if (take_ok) begin
        dp_vld <= 1'b1;
        dp_wr  <= i_hwrite;
        dp_idx <= a_idx;
        dp_be  <= a_be;
      end else if (o_hready) begin
        dp_vld <= 1'b0;
      end

      if (take_ok && !i_hwrite) o_hrdata <= rd_word;

      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= S_IDLE;
            o_hready <= 1'b1;
          end
          wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP1: begin
          state    <= S_RESP2;
          o_hready <= 1'b1;
        end
        default: begin
          // S_IDLE and S_RESP2 both end with hready high and may accept a new beat.
          state    <= S_IDLE;
          o_hready <= 1'b1;
          o_hresp  <= HRESP_OKAY;
          if (take_err) begin
            state    <= S_RESP1;
            o_hready <= 1'b0;
            o_hresp  <= HRESP_ERROR;
          end else if (take_retry) begin
            state    <= S_RESP1;
            o_hready <= 1'b0;
            o_hresp  <= HRESP_RETRY;
          end else if (take_ok && WAIT_STATES > 0) begin
            state    <= S_WAIT;
            o_hready <= 1'b0;
            wait_cnt <= 4'(WAIT_STATES);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate. Two instances share one AHB bus: u_dut0 has no wait states
// and u_dut1 has WS1 wait states. Beats are pipelined, and every data phase is compared
// against a transaction-level model of the memory contents, response type and wait count.
module tb_ahb_sram_subordinate;

  localparam int WS1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cur = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic        inj = 1'b0;

  logic        rdy0, rdy1;
  logic [1:0]  rsp0, rsp1;
  logic [31:0] rd0, rd1;
  logic        bus_rdy;
  logic [1:0]  bus_rsp;
  logic [31:0] bus_rd;

  always #5 clk = ~clk;

  assign bus_rdy = cur ? rdy1 : rdy0;
  assign bus_rsp = cur ? rsp1 : rsp0;
  assign bus_rd  = cur ? rd1  : rd0;

  ahb_sram_subordinate #(.DATA_WDT(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(!cur), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(bus_rdy), .o_hready(rdy0), .o_hresp(rsp0), .o_hrdata(rd0),
    .i_retry_inj(inj & !cur)
  );

  ahb_sram_subordinate #(.DATA_WDT(32), .DEPTH_LOG2(10), .WAIT_STATES(WS1)) u_dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(cur), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(bus_rdy), .o_hready(rdy1), .o_hresp(rsp1), .o_hrdata(rd1),
    .i_retry_inj(inj & cur)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: memory image and pending-retry flag per instance.
  logic [31:0] mm [2][1024];
  bit          retry_m [2];

  // Beat list for the next run.
  logic [31:0] b_addr [64];
  logic        b_wr   [64];
  logic [2:0]  b_size [64];
  logic [31:0] b_data [64];
  logic        b_seq  [64];
  logic        b_inj  [64];
  int          nb = 0;

  task automatic add(input logic [31:0] ad, input logic wr, input logic [2:0] sz,
                     input logic [31:0] dat, input logic sq, input logic ij);
    b_addr[nb] = ad; b_wr[nb] = wr; b_size[nb] = sz;
    b_data[nb] = dat; b_seq[nb] = sq; b_inj[nb] = ij;
    nb++;
  endtask

  task automatic add_rand();
    int          k;
    logic [2:0]  sz;
    logic [31:0] ad;
    k  = $urandom_range(0, 19);
    sz = 3'($urandom_range(0, 2));
    ad = (32'($urandom_range(0, 127)) << 2) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
    if (k == 0) sz = 3'd3;
    else if (k == 1) ad = ad | (32'h1000 << $urandom_range(0, 19));
    else if (k == 2) begin
      if (sz == 3'd0) sz = 3'd1;
      ad = (ad & ~32'd3) | 32'd1;
    end
    add(ad, 1'($urandom_range(0, 1)), sz, $urandom, 1'($urandom_range(0, 1)),
        $urandom_range(0, 9) == 0);
  endtask

  task automatic pulse_retry();
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    retry_m[int'(cur)] = 1'b1;
  endtask

  // Drives the beat list as a pipelined manager and checks every data phase.
  // The task is entered and left one time unit after a rising edge.
  task automatic run_beats();
    int          a = 0, d = -1, cyc = 0, waits = 0, ew = 0, u;
    logic [1:0]  er = 2'b00;
    logic        ed_rd = 1'b0;
    logic [31:0] edat = '0, dad = '0;
    u = int'(cur);
    while ((a < nb || d >= 0) && cyc < 400) begin
      if (a < nb) begin
        haddr  = b_addr[a];
        htrans = b_seq[a] ? 2'b11 : 2'b10;
        hwrite = b_wr[a];
        hsize  = b_size[a];
        hburst = b_seq[a] ? 3'b011 : 3'b000;
        inj    = b_inj[a] & bus_rdy;
      end else begin
        htrans = 2'b00;
        inj    = 1'b0;
      end
      hwdata = (d >= 0) ? b_data[d] : 32'h0;
      @(negedge clk);
      if (d >= 0) begin
        if (!bus_rdy) begin
          waits++;
          check($sformatf("wait_resp@%h", dad), 32'(bus_rsp), 32'(er));
        end else begin
          check($sformatf("resp@%h", dad), 32'(bus_rsp), 32'(er));
          check($sformatf("waits@%h", dad), 32'(waits), 32'(ew));
          if (er == 2'b00 && ed_rd) check($sformatf("rdata@%h", dad), bus_rd, edat);
          d = -1;
        end
      end
      if (a < nb && bus_rdy) begin : accept
        logic [31:0] ad;
        int          nby, off, w;
        ad  = b_addr[a];
        nby = 1 << b_size[a];
        off = int'(ad[1:0]);
        w   = int'(ad[11:2]);
        if ((ad >> 12) != 0 || b_size[a] > 3'd2 || (ad % nby) != 0) er = 2'b01;
        else if (retry_m[u]) begin
          er = 2'b10;
          retry_m[u] = 1'b0;
        end else begin
          er = 2'b00;
          if (b_wr[a]) begin
            for (int b = 0; b < 4; b++)
              if (b >= off && b < off + nby) mm[u][w][8*b +: 8] = b_data[a][8*b +: 8];
          end else begin
            edat = mm[u][w];
          end
        end
        if (b_inj[a]) retry_m[u] = 1'b1;
        ed_rd = !b_wr[a];
        ew    = (er != 2'b00) ? 1 : (u == 1 ? WS1 : 0);
        dad   = ad;
        waits = 0;
        d     = a;
        a++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 400) check("timeout_beats_left", 32'(nb - a), 32'd0);
    htrans = 2'b00;
    inj    = 1'b0;
    nb     = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hready0", 32'(rdy0), 32'd1);
    check("rst_hresp0",  32'(rsp0), 32'd0);
    check("rst_hrdata0", rd0, 32'd0);
    check("rst_hready1", 32'(rdy1), 32'd1);
    check("rst_hresp1",  32'(rsp1), 32'd0);
    check("rst_hrdata1", rd1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give both memories a known image for the low 128 words.
    for (int u = 0; u < 2; u++) begin
      cur = 1'(u);
      for (int w = 0; w < 128; w += 8) begin
        for (int i = 0; i < 8; i++) add(32'((w + i) * 4), 1'b1, 3'd2, $urandom, i > 0, 1'b0);
        run_beats();
      end
    end

    // Zero-wait INCR4 write then read-back.
    cur = 1'b0;
    for (int i = 0; i < 4; i++) add(32'h100 + 32'(4 * i), 1'b1, 3'd2, 32'hA0 + 32'(i), i > 0, 1'b0);
    run_beats();
    for (int i = 0; i < 4; i++) add(32'h100 + 32'(4 * i), 1'b0, 3'd2, 32'h0, i > 0, 1'b0);
    run_beats();

    // Byte lane merge into an existing word.
    add(32'h100, 1'b1, 3'd2, 32'h11223344, 1'b0, 1'b0);
    add(32'h103, 1'b1, 3'd0, 32'hEE000000, 1'b0, 1'b0);
    add(32'h100, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Back-to-back write then read of the same word.
    add(32'h40, 1'b1, 3'd2, 32'h55, 1'b0, 1'b0);
    add(32'h40, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Out-of-range and misaligned accesses must not touch the array.
    add(32'h0001_0000, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0);
    add(32'h101, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
    add(32'h100, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    add(32'h0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Injected RETRY, then the manager reissues the write.
    pulse_retry();
    add(32'h80, 1'b1, 3'd2, 32'h1234, 1'b0, 1'b0);
    run_beats();
    add(32'h80, 1'b1, 3'd2, 32'h1234, 1'b0, 1'b0);
    add(32'h80, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Injection on the same cycle a pending retry is consumed keeps the flag set.
    pulse_retry();
    add(32'h84, 1'b1, 3'd2, 32'h77, 1'b0, 1'b1);
    add(32'h84, 1'b1, 3'd2, 32'h78, 1'b0, 1'b0);
    add(32'h84, 1'b1, 3'd2, 32'h79, 1'b0, 1'b0);
    add(32'h84, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Wait-state instance: single read, then errors and retry.
    cur = 1'b1;
    add(32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();
    add(32'h0001_0000, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    add(32'h22, 1'b1, 3'd1, 32'hBEEF0000, 1'b0, 1'b0);
    add(32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();
    pulse_retry();
    add(32'h80, 1'b1, 3'd2, 32'h1234, 1'b0, 1'b0);
    add(32'h80, 1'b1, 3'd2, 32'h1234, 1'b0, 1'b0);
    add(32'h80, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    run_beats();

    // Randomized mixed traffic on both instances.
    for (int it = 0; it < 40; it++) begin
      cur = 1'($urandom_range(0, 1));
      for (int i = $urandom_range(1, 6); i > 0; i--) add_rand();
      run_beats();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
